// File: rtl/instr_prefetch_decoder.sv
// rtl/instr_prefetch_decoder.sv - MIPS fetch-and-decode front end with prefetch queue
module instr_prefetch_decoder #(
    parameter int                ADDR_W      = 32,
    parameter int                QUEUE_DEPTH = 4,
    parameter int                PC_INC      = 4,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           start,
    input  logic                           halt,
    input  logic                           redirect_valid,
    input  logic [ADDR_W-1:0]              redirect_pc,
    output logic                           imem_req,
    output logic [ADDR_W-1:0]              imem_addr,
    input  logic [31:0]                    imem_rdata,
    output logic                           dec_valid,
    input  logic                           dec_ready,
    output logic [ADDR_W-1:0]              dec_pc,
    output logic [5:0]                     opcode,
    output logic [4:0]                     rs,
    output logic [4:0]                     rt,
    output logic [4:0]                     rd,
    output logic [4:0]                     shamt,
    output logic [5:0]                     funct,
    output logic [15:0]                    imm,
    output logic [25:0]                    addr,
    output logic                           busy,
    output logic [$clog2(QUEUE_DEPTH):0]   queue_count
);

    localparam int PW = $clog2(QUEUE_DEPTH);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic [1:0]        state;
    logic [ADDR_W-1:0] fetch_pc;
    logic              inflight;
    logic [ADDR_W-1:0] inflight_pc;
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [PW:0]       count;
    logic [31:0]       q_data [QUEUE_DEPTH];
    logic [ADDR_W-1:0] q_pc   [QUEUE_DEPTH];

    logic              nonempty;
    logic              push;
    logic              pop;
    logic [PW+1:0]     occupancy;
    logic [31:0]       head_word;

    assign nonempty  = (count != '0);
    assign dec_valid = nonempty && !redirect_valid;
    assign pop       = dec_valid && dec_ready;
    // A redirect kills the response of the previous request in the same cycle.
    assign push      = inflight && !redirect_valid;

    // Reserve a slot for every outstanding read so a push can never overflow.
    assign occupancy = {1'b0, count} + (PW+2)'(inflight) - (PW+2)'(pop);
    assign imem_req  = (state == RUN) && !redirect_valid
                       && (occupancy < (PW+2)'(QUEUE_DEPTH));
    assign imem_addr = fetch_pc;

    assign busy        = (state != IDLE);
    assign queue_count = count;

    assign head_word = nonempty ? q_data[rd_ptr] : '0;
    assign dec_pc    = nonempty ? q_pc[rd_ptr] : '0;
    assign opcode    = head_word[31:26];
    assign rs        = head_word[25:21];
    assign rt        = head_word[20:16];
    assign rd        = head_word[15:11];
    assign shamt     = head_word[10:6];
    assign funct     = head_word[5:0];
    assign imm       = head_word[15:0];
    assign addr      = head_word[25:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
        end else begin
            inflight <= imem_req;
            if (imem_req) begin
                inflight_pc <= fetch_pc;
            end
            if (redirect_valid) begin
                fetch_pc <= redirect_pc;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                count    <= '0;
                if (state == DRAIN) begin
                    state <= IDLE;
                end
            end else begin
                if (imem_req) begin
                    fetch_pc <= fetch_pc + ADDR_W'(PC_INC);
                end
                if (push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                count <= count + (PW+1)'(push) - (PW+1)'(pop);
                case (state)
                    IDLE:    if (start) state <= RUN;
                    RUN:     if (halt) state <= DRAIN;
                    DRAIN:   if (count == '0 && !inflight) state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Queue storage needs no reset: entries are only read while counted valid.
    always_ff @(posedge clk) begin
        if (push) begin
            q_data[wr_ptr] <= imem_rdata;
            q_pc[wr_ptr]   <= inflight_pc;
        end
    end

endmodule

// File: tb/tb_instr_prefetch_decoder.sv
// tb/tb_instr_prefetch_decoder.sv - directed self-checking bench for instr_prefetch_decoder
module tb_instr_prefetch_decoder;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        start = 1'b0, halt = 1'b0, redirect_valid = 1'b0, dec_ready = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req, dec_valid, busy;
    logic [31:0] imem_addr, imem_rdata, dec_pc;
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm;
    logic [25:0] addr;
    logic [2:0]  queue_count;

    logic        d2_start = 1'b0, d2_halt = 1'b0, d2_redirect_valid = 1'b0, d2_dec_ready = 1'b0;
    logic [31:0] d2_redirect_pc = '0;
    logic        d2_imem_req, d2_dec_valid, d2_busy;
    logic [31:0] d2_imem_addr, d2_imem_rdata, d2_dec_pc;
    logic [5:0]  d2_opcode, d2_funct;
    logic [4:0]  d2_rs, d2_rt, d2_rd, d2_shamt;
    logic [15:0] d2_imm;
    logic [25:0] d2_addr;
    logic [1:0]  d2_queue_count;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    instr_prefetch_decoder #(.ADDR_W(32), .QUEUE_DEPTH(4), .PC_INC(4), .RESET_PC(32'h0)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .halt(halt),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_pc(dec_pc),
        .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
        .imm(imm), .addr(addr), .busy(busy), .queue_count(queue_count)
    );

    instr_prefetch_decoder #(.ADDR_W(32), .QUEUE_DEPTH(2), .PC_INC(4), .RESET_PC(32'h0)) dut2 (
        .clk(clk), .reset_n(reset_n), .start(d2_start), .halt(d2_halt),
        .redirect_valid(d2_redirect_valid), .redirect_pc(d2_redirect_pc),
        .imem_req(d2_imem_req), .imem_addr(d2_imem_addr), .imem_rdata(d2_imem_rdata),
        .dec_valid(d2_dec_valid), .dec_ready(d2_dec_ready), .dec_pc(d2_dec_pc),
        .opcode(d2_opcode), .rs(d2_rs), .rt(d2_rt), .rd(d2_rd), .shamt(d2_shamt), .funct(d2_funct),
        .imm(d2_imm), .addr(d2_addr), .busy(d2_busy), .queue_count(d2_queue_count)
    );

    function automatic logic [31:0] instr_at(input logic [31:0] pc);
        if (pc == 32'h0)      return 32'h0000_0000;
        else if (pc == 32'h4) return 32'hFFFF_FFFF;
        else                  return {pc[15:0] ^ 16'hA5A5, pc[15:0]};
    endfunction

    // One-cycle-latency instruction memories.
    always @(posedge clk) imem_rdata    <= imem_req    ? instr_at(imem_addr)    : 32'hDEAD_BEEF;
    always @(posedge clk) d2_imem_rdata <= d2_imem_req ? instr_at(d2_imem_addr) : 32'hDEAD_BEEF;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        start = 0; halt = 0; redirect_valid = 0; redirect_pc = '0; dec_ready = 0;
        d2_start = 0; d2_dec_ready = 0;
        reset_n = 0;
        tick();
        tick();
        reset_n = 1;
        tick();
    endtask

    task automatic pulse_start();
        start = 1;
        tick();
        start = 0;
    endtask

    task automatic test_reset();
        reset_n = 0;
        #1;
        n_total++;
        if ({imem_req, dec_valid, busy} !== 3'b000) begin
            n_bad++; $display("FAIL reset_ctrl got=%b want=000", {imem_req, dec_valid, busy});
        end
        n_total++;
        if (imem_addr !== 32'h0 || dec_pc !== 32'h0 || queue_count !== 3'd0) begin
            n_bad++; $display("FAIL reset_regs addr=%h pc=%h cnt=%0d want 0", imem_addr, dec_pc, queue_count);
        end
        n_total++;
        if ({opcode, rs, rt, rd, shamt, funct, imm, addr} !== 74'h0) begin
            n_bad++; $display("FAIL reset_fields got=%h want=0", {opcode, rs, rt, rd, shamt, funct, imm, addr});
        end
        do_reset();
        n_total++;
        if (imem_req !== 1'b0 || busy !== 1'b0) begin
            n_bad++; $display("FAIL idle_after_reset req=%b busy=%b want 0 0", imem_req, busy);
        end
    endtask

    task automatic test_basic_decode();
        do_reset();
        dec_ready = 1;
        pulse_start();
        n_total++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            n_bad++; $display("FAIL first_req req=%b addr=%h want 1 0", imem_req, imem_addr);
        end
        tick();
        n_total++;
        if (dec_valid !== 1'b0) begin
            n_bad++; $display("FAIL fill_latency dec_valid=%b want 0", dec_valid);
        end
        tick();
        n_total++;
        if (dec_valid !== 1'b1 || dec_pc !== 32'h0 || {opcode, rs, rt, rd, shamt, funct, imm, addr} !== 74'h0) begin
            n_bad++; $display("FAIL decode_word0 valid=%b pc=%h fields=%h want 1 0 0", dec_valid, dec_pc,
                              {opcode, rs, rt, rd, shamt, funct, imm, addr});
        end
        tick();
        n_total++;
        if (dec_valid !== 1'b1 || dec_pc !== 32'h4 || rs !== 5'h1F || rt !== 5'h1F || rd !== 5'h1F
            || imm !== 16'hFFFF || addr !== 26'h3FF_FFFF || opcode !== 6'h3F || shamt !== 5'h1F || funct !== 6'h3F) begin
            n_bad++; $display("FAIL decode_word1 pc=%h rs=%h rt=%h rd=%h imm=%h addr=%h want 4 1f 1f 1f ffff 3ffffff",
                              dec_pc, rs, rt, rd, imm, addr);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_pc;
        do_reset();
        dec_ready = 0;
        pulse_start();
        repeat (10) tick();
        n_total++;
        if (queue_count !== 3'd4 || imem_req !== 1'b0) begin
            n_bad++; $display("FAIL bp_full cnt=%0d req=%b want 4 0", queue_count, imem_req);
        end
        n_total++;
        if (dec_valid !== 1'b1 || dec_pc !== 32'h0 || imm !== 16'h0) begin
            n_bad++; $display("FAIL bp_head_stable valid=%b pc=%h imm=%h want 1 0 0", dec_valid, dec_pc, imm);
        end
        dec_ready = 1;
        #1;
        for (int i = 0; i < 12; i++) begin
            exp_pc = 32'(i * 4);
            n_total++;
            if (dec_valid !== 1'b1 || dec_pc !== exp_pc) begin
                n_bad++; $display("FAIL bp_drain[%0d] valid=%b pc=%h want 1 %h", i, dec_valid, dec_pc, exp_pc);
            end
            if (i >= 2) begin
                n_total++;
                if (imm !== exp_pc[15:0]) begin
                    n_bad++; $display("FAIL bp_imm[%0d] got=%h want=%h", i, imm, exp_pc[15:0]);
                end
            end
            tick();
        end
    endtask

    task automatic test_redirect();
        do_reset();
        dec_ready = 0;
        pulse_start();
        repeat (4) tick();
        n_total++;
        if (queue_count !== 3'd3) begin
            n_bad++; $display("FAIL redir_setup cnt=%0d want 3", queue_count);
        end
        redirect_valid = 1;
        redirect_pc = 32'h40;
        #1;
        n_total++;
        if (dec_valid !== 1'b0 || imem_req !== 1'b0) begin
            n_bad++; $display("FAIL redir_gate valid=%b req=%b want 0 0", dec_valid, imem_req);
        end
        tick();
        redirect_valid = 0;
        #1;
        n_total++;
        if (queue_count !== 3'd0 || dec_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h40) begin
            n_bad++; $display("FAIL redir_flush cnt=%0d valid=%b req=%b addr=%h want 0 0 1 40",
                              queue_count, dec_valid, imem_req, imem_addr);
        end
        tick();
        tick();
        n_total++;
        if (dec_valid !== 1'b1 || dec_pc !== 32'h40 || queue_count !== 3'd1) begin
            n_bad++; $display("FAIL redir_target valid=%b pc=%h cnt=%0d want 1 40 1", dec_valid, dec_pc, queue_count);
        end
        dec_ready = 1;
        tick();
        n_total++;
        if (dec_valid !== 1'b1 || dec_pc !== 32'h44) begin
            n_bad++; $display("FAIL redir_next valid=%b pc=%h want 1 44", dec_valid, dec_pc);
        end
    endtask

    task automatic test_halt_drain();
        int delivered = 0;
        do_reset();
        dec_ready = 0;
        pulse_start();
        tick();
        tick();
        halt = 1;
        tick();
        halt = 0;
        n_total++;
        if (busy !== 1'b1 || queue_count !== 3'd2 || imem_req !== 1'b0) begin
            n_bad++; $display("FAIL halt_enter busy=%b cnt=%0d req=%b want 1 2 0", busy, queue_count, imem_req);
        end
        dec_ready = 1;
        #1;
        for (int i = 0; i < 8; i++) begin
            n_total++;
            if (imem_req !== 1'b0) begin
                n_bad++; $display("FAIL drain_req[%0d] got=%b want 0", i, imem_req);
            end
            if (dec_valid === 1'b1) begin
                n_total++;
                if (dec_pc !== 32'(delivered * 4)) begin
                    n_bad++; $display("FAIL drain_pc[%0d] got=%h want=%h", delivered, dec_pc, 32'(delivered * 4));
                end
                delivered++;
            end
            tick();
        end
        n_total++;
        if (delivered != 3 || busy !== 1'b0) begin
            n_bad++; $display("FAIL drain_done delivered=%0d busy=%b want 3 0", delivered, busy);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        redirect_valid = 1;
        redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 0;
        n_total++;
        if (busy !== 1'b0 || imem_req !== 1'b0 || imem_addr !== 32'hFFFF_FFFC) begin
            n_bad++; $display("FAIL idle_redirect busy=%b req=%b addr=%h want 0 0 fffffffc", busy, imem_req, imem_addr);
        end
        dec_ready = 1;
        pulse_start();
        n_total++;
        if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin
            n_bad++; $display("FAIL wrap_req0 req=%b addr=%h want 1 fffffffc", imem_req, imem_addr);
        end
        tick();
        n_total++;
        if (imem_addr !== 32'h0) begin
            n_bad++; $display("FAIL wrap_addr got=%h want=0", imem_addr);
        end
        tick();
        n_total++;
        if (dec_valid !== 1'b1 || dec_pc !== 32'hFFFF_FFFC || imm !== 16'hFFFC) begin
            n_bad++; $display("FAIL wrap_head valid=%b pc=%h imm=%h want 1 fffffffc fffc", dec_valid, dec_pc, imm);
        end
        tick();
        n_total++;
        if (dec_valid !== 1'b1 || dec_pc !== 32'h0) begin
            n_bad++; $display("FAIL wrap_next valid=%b pc=%h want 1 0", dec_valid, dec_pc);
        end
    endtask

    task automatic test_depth2_throughput();
        do_reset();
        d2_dec_ready = 1;
        d2_start = 1;
        tick();
        d2_start = 0;
        tick();
        tick();
        for (int i = 0; i < 10; i++) begin
            n_total++;
            if (d2_dec_valid !== 1'b1 || d2_dec_pc !== 32'(i * 4) || d2_queue_count > 2'd2) begin
                n_bad++; $display("FAIL d2_stream[%0d] valid=%b pc=%h cnt=%0d want 1 %h <=2",
                                  i, d2_dec_valid, d2_dec_pc, d2_queue_count, 32'(i * 4));
            end
            tick();
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        dec_ready = 0;
        pulse_start();
        repeat (3) tick();
        #2;
        reset_n = 0;
        #1;
        n_total++;
        if ({imem_req, dec_valid, busy} !== 3'b000 || queue_count !== 3'd0 || imem_addr !== 32'h0
            || dec_pc !== 32'h0 || {opcode, rs, rt, rd, shamt, funct, imm, addr} !== 74'h0) begin
            n_bad++; $display("FAIL async_reset req=%b valid=%b busy=%b cnt=%0d addr=%h pc=%h want all 0",
                              imem_req, dec_valid, busy, queue_count, imem_addr, dec_pc);
        end
        #1;
        reset_n = 1;
        tick();
        n_total++;
        if (queue_count !== 3'd0 || dec_valid !== 1'b0 || busy !== 1'b0) begin
            n_bad++; $display("FAIL async_stale cnt=%0d valid=%b busy=%b want 0 0 0", queue_count, dec_valid, busy);
        end
        dec_ready = 1;
        pulse_start();
        tick();
        tick();
        n_total++;
        if (dec_valid !== 1'b1 || dec_pc !== 32'h0) begin
            n_bad++; $display("FAIL async_restart valid=%b pc=%h want 1 0", dec_valid, dec_pc);
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_basic_decode();
        test_backpressure();
        test_redirect();
        test_halt_drain();
        test_wrap();
        test_depth2_throughput();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/instr_prefetch_decoder.md
# instr_prefetch_decoder

Parametrised fetch-and-decode front end for the single-cycle MIPS datapath. It issues sequential reads to a one-cycle-latency instruction memory and buffers the returned words in a QUEUE_DEPTH-entry FIFO. It splits the head word into R/I/J fields and hands them to the control unit over a valid/ready handshake. Branch and jump redirects flush the queue and any in-flight read. A start/halt state machine gates fetching.

## Interface
- ADDR_W, 32: PC and instruction-memory address width.
- QUEUE_DEPTH, 4: instruction queue entries; power of two, ≥ 2.
- PC_INC, 4: PC increment per instruction, in bytes.
- RESET_PC, 0: fetch PC after reset.
- clk  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  begin fetching from fetch_pc; ignored outside IDLE.
- halt  in  1  stop fetching and drain; ignored outside RUN.
- redirect_valid  in  1  flush and reload fetch_pc.
- redirect_pc  in  ADDR_W  new fetch PC.
- imem_req  out  1  read request for this cycle.
- imem_addr  out  ADDR_W  read address, equal to fetch_pc.
- imem_rdata  in  32  read data, valid in the cycle after the request edge.
- dec_valid  out  1  head instruction available.
- dec_ready  in  1  consumer accepts the head.
- dec_pc  out  ADDR_W  PC of the head instruction.
- opcode  out  6  bits [31:26].
- rs, rt, rd  out  5 each  bits [25:21], [20:16], [15:11].
- shamt  out  5  bits [10:6].
- funct  out  6  bits [5:0].
- imm  out  16  bits [15:0].
- addr  out  26  bits [25:0].
- busy  out  1  state is not IDLE.
- queue_count  out  $clog2(QUEUE_DEPTH)+1  queue occupancy.

## Operation
- States:
  - IDLE: start → RUN.
  - RUN: halt → DRAIN. If start and halt are asserted together, halt wins.
  - DRAIN: count==0 and no read in flight → IDLE.
- Request rule: imem_req = (state==RUN) && !redirect_valid && (count + inflight − pop < QUEUE_DEPTH), where pop = dec_valid && dec_ready.
  - imem_req is combinational.
  - Each request edge advances fetch_pc by PC_INC (modulo 2^ADDR_W) and sets inflight for one cycle.
- Response handling: in the cycle after a request edge, imem_rdata and its PC are pushed at the next edge.
  - A push can never overflow, by the request rule.
  - Responses are still accepted in DRAIN.
- Dequeue: dec_valid = (count != 0) && !redirect_valid. Push and pop on the same edge leave count unchanged.
- Field outputs decode the head entry combinationally. All field outputs and dec_pc are 0 when the queue is empty.
- Redirect (highest priority, every state):
  - The queue is cleared.
  - Any response arriving in that cycle is discarded.
  - No pop occurs.
  - fetch_pc <= redirect_pc.
  - In RUN, fetching resumes at redirect_pc.
  - In DRAIN, the state goes to IDLE.
  - In IDLE, only fetch_pc is updated.

## Timing
- Reset values:
  - state IDLE, fetch_pc = RESET_PC.
  - imem_req 0, imem_addr = RESET_PC.
  - dec_valid 0, dec_pc 0, all fields 0.
  - busy 0, queue_count 0, inflight 0.
- Reset asserted mid-operation behaves identically: the queue and inflight are dropped immediately, and a response arriving after release is ignored.
- start high in cycle 0 → imem_req high in cycle 1 → data in cycle 2 → dec_valid high in cycle 3. Fill latency is 3 cycles.
- Redirect edge → first request at redirect_pc in the next cycle → dec_valid 2 cycles after that.
- With dec_ready held high, steady-state throughput is one instruction per cycle.
- With dec_ready low, fetching stops once QUEUE_DEPTH words are queued or in flight. dec_valid and the fields stay stable until accepted.
- Wrap-around: fetch_pc at 2^ADDR_W − PC_INC wraps to 0.

## Test plan
- Basic decode: memory word 0 = 0x0000_0000, word 1 = 0xFFFF_FFFF, dec_ready=1, start pulse → first output has dec_pc 0 and all fields 0. Second output has dec_pc 4, rs/rt/rd = 5'h1F, imm 16'hFFFF, addr 26'h3FF_FFFF.
- Backpressure: dec_ready=0 for 10 cycles after start → queue_count settles at 4, imem_req low, head fields unchanged. Releasing dec_ready drains PCs 0, 4, 8, 12, 16… in order with no gap or duplicate.
- Redirect: redirect_pc=0x40 while the queue holds 3 entries and a read is in flight → same edge queue_count 0, in-flight word discarded, next dec_pc 0x40.
- Halt/drain: halt with 2 queued and 1 in flight, dec_ready=1 → 3 more instructions delivered, then busy drops and imem_req stays 0.
- Simultaneous push/pop at full rate with QUEUE_DEPTH=2 → one instruction per cycle, queue_count never exceeds 2.
- Async reset pulse mid-RUN → all outputs return to reset values without a clock edge; a restart fetches from RESET_PC.
